// File: rtl/conv_sequencer.sv
// Instruction sequencer for the CNN accelerator: accepts repeatable instructions and drives
// neuron/kernel buffer addresses, bank selects and strobes, one step per EXEC cycle.
module conv_sequencer #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned AB        = 11,
  parameter int unsigned AL        = 7,
  parameter int unsigned W         = 16,
  parameter int unsigned RPT_W     = 8,
  parameter int unsigned INS_WIDTH = 4 + 2 + 2 + RPT_W + W
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [INS_WIDTH-1:0] instruction,
  output logic [AB-1:0]        n_read_addr,
  output logic [AB-1:0]        n_write_addr,
  output logic [AB-1:0]        k_addr,
  output logic [DEPTH-1:0]     n_bank_sel,
  output logic [DEPTH-1:0]     k_bank_sel,
  output logic                 n_load_en,
  output logic                 n_read_en,
  output logic                 n_write_en,
  output logic                 k_write_en,
  output logic [W-1:0]         wdata,
  output logic                 do_pooling,
  output logic                 busy,
  output logic                 err_illegal
);

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpLoadC = 4'd1;
  localparam logic [3:0] OpLoadK = 4'd2;
  localparam logic [3:0] OpLoadN = 4'd3;
  localparam logic [3:0] OpReadN = 4'd4;
  localparam logic [3:0] OpConv  = 4'd5;
  localparam logic [3:0] OpPool  = 4'd6;

  typedef enum logic {StIdle, StExec} state_t;

  state_t                 state_q, state_d;
  logic [INS_WIDTH-1:0]   ins_q;
  logic [RPT_W-1:0]       cnt_q, cnt_d;
  logic [AB-1:0]          k_row_q, k_col_q, r_row_q, r_col_q, w_row_q, w_col_q;
  logic [AB-1:0]          k_row_d, k_col_d, r_row_d, r_col_d, w_row_d, w_col_d;
  logic [AB-1:0]          k_addr_d, r_addr_d, w_addr_d;
  logic [DEPTH-1:0]       k_bank_d, n_bank_d;
  logic [AL-1:0]          ks_q, ns_q, p_q, ps_q, ks_d, ns_d, p_d, ps_d;
  logic                   k_we_d, n_ld_d, n_rd_d, n_we_d, pool_d, err_d;
  logic [W-1:0]           wdata_d;
  logic [AB-1:0]          ks_e, ns_e, p_e, ps_e, rstep_pool;

  logic [3:0]       op, op_in;
  logic [1:0]       mode, sub;
  logic [W-1:0]     imm;
  logic [RPT_W-1:0] rpt_in;
  logic             accept, step, last;

  assign op     = ins_q[INS_WIDTH-1 -: 4];
  assign mode   = ins_q[INS_WIDTH-5 -: 2];
  assign sub    = ins_q[INS_WIDTH-7 -: 2];
  assign imm    = ins_q[W-1:0];
  assign op_in  = instruction[INS_WIDTH-1 -: 4];
  assign rpt_in = instruction[W +: RPT_W];

  assign ins_ready = (state_q == StIdle) || (cnt_q == '0);
  assign accept    = ins_valid && ins_ready;
  assign step      = (state_q == StExec);
  assign last      = (cnt_q == '0);
  assign busy      = (state_q == StExec);

  assign ks_e       = AB'(ks_q);
  assign ns_e       = AB'(ns_q);
  assign p_e        = AB'(p_q);
  assign ps_e       = AB'(ps_q);
  assign rstep_pool = ns_e * p_e;

  // Returns {row, col} after applying one mode step; INCR jumps rows at col == stp-1.
  function automatic logic [2*AB-1:0] move(input logic [1:0] m, input logic [AB-1:0] stp,
                                           input logic [AB-1:0] row, input logic [AB-1:0] col);
    logic [AB-1:0] r, c;
    r = row;
    c = col;
    case (m)
      2'b00: begin r = '0; c = '0; end
      2'b01: ;
      2'b10: begin
        if (stp != '0 && col == stp - AB'(1)) begin
          c = '0;
          r = row + AB'(1);
        end else begin
          c = col + AB'(1);
        end
      end
      default: begin c = '0; r = row + AB'(1); end
    endcase
    return {r, c};
  endfunction

  function automatic logic [DEPTH-1:0] bank_next(input logic [1:0] s, input logic [DEPTH-1:0] b);
    case (s)
      2'b00:   return '0;
      2'b10:   return b + DEPTH'(1);
      default: return b;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_row_d  = k_row_q;
    k_col_d  = k_col_q;
    r_row_d  = r_row_q;
    r_col_d  = r_col_q;
    w_row_d  = w_row_q;
    w_col_d  = w_col_q;
    k_addr_d = k_addr;
    r_addr_d = n_read_addr;
    w_addr_d = n_write_addr;
    k_bank_d = k_bank_sel;
    n_bank_d = n_bank_sel;
    ks_d     = ks_q;
    ns_d     = ns_q;
    p_d      = p_q;
    ps_d     = ps_q;
    err_d    = err_illegal;
    wdata_d  = wdata;
    k_we_d   = 1'b0;
    n_ld_d   = 1'b0;
    n_rd_d   = 1'b0;
    n_we_d   = 1'b0;
    pool_d   = 1'b0;

    if (accept) begin
      state_d = StExec;
      // LOAD_CONST and illegal opcodes always take a single step.
      cnt_d   = (op_in == OpLoadC || op_in > OpPool) ? '0 : rpt_in;
    end else if (step && last) begin
      state_d = StIdle;
    end else if (step) begin
      cnt_d = cnt_q - RPT_W'(1);
    end

    if (step) begin
      case (op)
        OpNop: wdata_d = imm;
        OpLoadC: begin
          wdata_d = imm;
          case (sub)
            2'd0:    ks_d = imm[AL-1:0];
            2'd1:    ns_d = imm[AL-1:0];
            2'd2:    p_d  = imm[AL-1:0];
            default: ps_d = imm[AL-1:0];
          endcase
        end
        OpLoadK: begin
          wdata_d            = imm;
          {k_row_d, k_col_d} = move(mode, ks_e, k_row_q, k_col_q);
          k_bank_d           = bank_next(sub, k_bank_sel);
          k_addr_d           = k_row_d * ks_e + k_col_d;
          k_we_d             = 1'b1;
        end
        OpLoadN, OpReadN: begin
          wdata_d            = imm;
          {r_row_d, r_col_d} = move(mode, ns_e, r_row_q, r_col_q);
          n_bank_d           = bank_next(sub, n_bank_sel);
          r_addr_d           = r_row_d * ns_e + r_col_d;
          n_ld_d             = (op == OpLoadN);
          n_rd_d             = (op == OpReadN);
        end
        OpConv: begin
          wdata_d            = imm;
          {w_row_d, w_col_d} = move(mode, ns_e, w_row_q, w_col_q);
          w_addr_d           = w_row_d * ns_e + w_col_d;
          n_we_d             = 1'b1;
        end
        OpPool: begin
          wdata_d            = imm;
          {r_row_d, r_col_d} = move(mode, rstep_pool, r_row_q, r_col_q);
          {w_row_d, w_col_d} = move(mode, ps_e, w_row_q, w_col_q);
          r_addr_d           = r_row_d * rstep_pool + r_col_d;
          w_addr_d           = w_row_d * ps_e + w_col_d;
          pool_d             = 1'b1;
          n_we_d             = (sub == 2'b11);
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      ins_q        <= '0;
      cnt_q        <= '0;
      k_row_q      <= '0;
      k_col_q      <= '0;
      r_row_q      <= '0;
      r_col_q      <= '0;
      w_row_q      <= '0;
      w_col_q      <= '0;
      k_addr       <= '0;
      n_read_addr  <= '0;
      n_write_addr <= '0;
      k_bank_sel   <= '0;
      n_bank_sel   <= '0;
      ks_q         <= '0;
      ns_q         <= '0;
      p_q          <= AL'(1);
      ps_q         <= '0;
      err_illegal  <= 1'b0;
      wdata        <= '0;
      k_write_en   <= 1'b0;
      n_load_en    <= 1'b0;
      n_read_en    <= 1'b0;
      n_write_en   <= 1'b0;
      do_pooling   <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (accept) ins_q <= instruction;
      cnt_q        <= cnt_d;
      k_row_q      <= k_row_d;
      k_col_q      <= k_col_d;
      r_row_q      <= r_row_d;
      r_col_q      <= r_col_d;
      w_row_q      <= w_row_d;
      w_col_q      <= w_col_d;
      k_addr       <= k_addr_d;
      n_read_addr  <= r_addr_d;
      n_write_addr <= w_addr_d;
      k_bank_sel   <= k_bank_d;
      n_bank_sel   <= n_bank_d;
      ks_q         <= ks_d;
      ns_q         <= ns_d;
      p_q          <= p_d;
      ps_q         <= ps_d;
      err_illegal  <= err_d;
      wdata        <= wdata_d;
      k_write_en   <= k_we_d;
      n_load_en    <= n_ld_d;
      n_read_en    <= n_rd_d;
      n_write_en   <= n_we_d;
      do_pooling   <= pool_d;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: directed scenarios plus random programs scored
// against a step-level behavioural model.
module tb_conv_sequencer;
  localparam int DEPTH = 2, AB = 11, AL = 7, W = 16, RPT_W = 8, IW = 4 + 2 + 2 + RPT_W + W;
  localparam int MASK = (1 << AB) - 1;

  logic CLK = 1'b0, RSTN = 1'b0, ins_valid = 1'b0;
  logic [IW-1:0] instruction = '0;
  logic ins_ready, n_load_en, n_read_en, n_write_en, k_write_en, do_pooling, busy, err_illegal;
  logic [AB-1:0] n_read_addr, n_write_addr, k_addr;
  logic [DEPTH-1:0] n_bank_sel, k_bank_sel;
  logic [W-1:0] wdata;

  int checks = 0, errors = 0;

  // Model state: counters as plain integers, addresses derived from row*step+col.
  int  m_kr, m_kc, m_rr, m_rc, m_wr, m_wc, m_kb, m_nb, m_ks, m_ns, m_p, m_ps;
  int  m_ka, m_ra, m_wa, m_wd;
  bit  m_kwe, m_ld, m_rd, m_nwe, m_pool, m_err;
  int  obs_k[$], obs_r[$], obs_w[$], obs_nb[$];
  bit  obs_kwe[$], obs_pool[$], obs_nwe[$], obs_any[$];

  conv_sequencer #(.DEPTH(DEPTH), .AB(AB), .AL(AL), .W(W), .RPT_W(RPT_W), .INS_WIDTH(IW)) dut (
    .CLK(CLK), .RSTN(RSTN), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .instruction(instruction), .n_read_addr(n_read_addr), .n_write_addr(n_write_addr),
    .k_addr(k_addr), .n_bank_sel(n_bank_sel), .k_bank_sel(k_bank_sel), .n_load_en(n_load_en),
    .n_read_en(n_read_en), .n_write_en(n_write_en), .k_write_en(k_write_en), .wdata(wdata),
    .do_pooling(do_pooling), .busy(busy), .err_illegal(err_illegal)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mk(input int op, input int mode, input int sub,
                                       input int rpt, input int imm);
    logic [3:0] o; logic [1:0] m, s; logic [RPT_W-1:0] r; logic [W-1:0] i;
    o = op[3:0]; m = mode[1:0]; s = sub[1:0]; r = rpt[RPT_W-1:0]; i = imm[W-1:0];
    return {o, m, s, r, i};
  endfunction

  function automatic int steps_of(input logic [IW-1:0] ins);
    int op = int'(ins[IW-1 -: 4]);
    if (op == 1 || op > 6) return 1;
    return int'(ins[W +: RPT_W]) + 1;
  endfunction

  task automatic model_reset();
    {m_kr, m_kc, m_rr, m_rc, m_wr, m_wc, m_kb, m_nb} = '0;
    {m_ks, m_ns, m_ps, m_ka, m_ra, m_wa, m_wd} = '0;
    m_p = 1;
    {m_kwe, m_ld, m_rd, m_nwe, m_pool, m_err} = '0;
  endtask

  task automatic mv(input int mode, input int stp, inout int row, inout int col);
    case (mode)
      0: begin row = 0; col = 0; end
      1: ;
      2: if (stp != 0 && col == stp - 1) begin col = 0; row = row + 1; end else col = col + 1;
      default: begin col = 0; row = row + 1; end
    endcase
    row = row & MASK;
    col = col & MASK;
  endtask

  function automatic int bank(input int sub, input int b);
    if (sub == 0) return 0;
    if (sub == 2) return (b + 1) % (1 << DEPTH);
    return b;
  endfunction

  task automatic model_step(input logic [IW-1:0] ins);
    int op, mode, sub, imm, rs;
    op = int'(ins[IW-1 -: 4]); mode = int'(ins[IW-5 -: 2]);
    sub = int'(ins[IW-7 -: 2]); imm = int'(ins[W-1:0]);
    {m_kwe, m_ld, m_rd, m_nwe, m_pool} = '0;
    if (op > 6) begin m_err = 1; return; end
    m_wd = imm;
    case (op)
      1: case (sub)
           0: m_ks = imm % (1 << AL);
           1: m_ns = imm % (1 << AL);
           2: m_p  = imm % (1 << AL);
           default: m_ps = imm % (1 << AL);
         endcase
      2: begin
        mv(mode, m_ks, m_kr, m_kc); m_kb = bank(sub, m_kb);
        m_ka = (m_kr * m_ks + m_kc) & MASK; m_kwe = 1;
      end
      3, 4: begin
        mv(mode, m_ns, m_rr, m_rc); m_nb = bank(sub, m_nb);
        m_ra = (m_rr * m_ns + m_rc) & MASK; m_ld = (op == 3); m_rd = (op == 4);
      end
      5: begin
        mv(mode, m_ns, m_wr, m_wc); m_wa = (m_wr * m_ns + m_wc) & MASK; m_nwe = 1;
      end
      6: begin
        rs = (m_ns * m_p) & MASK;
        mv(mode, rs, m_rr, m_rc); mv(mode, m_ps, m_wr, m_wc);
        m_ra = (m_rr * rs + m_rc) & MASK; m_wa = (m_wr * m_ps + m_wc) & MASK;
        m_pool = 1; m_nwe = (sub == 3);
      end
      default: ;
    endcase
  endtask

  // b2b_mode: 0 = gap between instructions, 1 = always back-to-back, 2 = random.
  task automatic run_program(input logic [IW-1:0] prog[$], input int b2b_mode);
    bit pend, take, exp_busy;
    logic [3*AB+2*DEPTH-1:0] exp_a, got_a;
    logic [W+6:0] exp_f, got_f;
    pend = 0;
    for (int i = 0; i < prog.size(); i++) begin
      int n = steps_of(prog[i]);
      if (!pend) begin
        instruction = prog[i]; ins_valid = 1'b1;
        checks++;
        if (ins_ready !== 1'b1) begin
          errors++; $display("FAIL idle_ready ins %0d: got %b, required 1", i, ins_ready);
        end
        @(posedge CLK); #1; ins_valid = 1'b0;
        {m_kwe, m_ld, m_rd, m_nwe, m_pool} = '0;
        exp_f = {m_kwe, m_ld, m_rd, m_nwe, m_pool, m_err, 1'b1, m_wd[W-1:0]};
        got_f = {k_write_en, n_load_en, n_read_en, n_write_en, do_pooling, err_illegal, busy, wdata};
        checks++;
        if (got_f !== exp_f) begin
          errors++; $display("FAIL accept_cycle ins %0d: got %h, required %h", i, got_f, exp_f);
        end
      end
      for (int k = 0; k < n; k++) begin
        take = (k == n - 1) && (i + 1 < prog.size()) &&
               (b2b_mode == 1 || (b2b_mode == 2 && $urandom_range(0, 1) == 1));
        if (take) begin instruction = prog[i+1]; ins_valid = 1'b1; end
        checks++;
        if (ins_ready !== (k == n - 1)) begin
          errors++; $display("FAIL step_ready ins %0d step %0d: got %b, required %b",
                             i, k, ins_ready, (k == n - 1));
        end
        @(posedge CLK); #1; ins_valid = 1'b0;
        model_step(prog[i]);
        exp_busy = !((k == n - 1) && !take);
        exp_a = {m_ka[AB-1:0], m_ra[AB-1:0], m_wa[AB-1:0], m_kb[DEPTH-1:0], m_nb[DEPTH-1:0]};
        got_a = {k_addr, n_read_addr, n_write_addr, k_bank_sel, n_bank_sel};
        exp_f = {m_kwe, m_ld, m_rd, m_nwe, m_pool, m_err, exp_busy, m_wd[W-1:0]};
        got_f = {k_write_en, n_load_en, n_read_en, n_write_en, do_pooling, err_illegal, busy, wdata};
        checks++;
        if (got_a !== exp_a) begin
          errors++; $display("FAIL step_addr ins %0d step %0d: got %h, required %h",
                             i, k, got_a, exp_a);
        end
        checks++;
        if (got_f !== exp_f) begin
          errors++; $display("FAIL step_flags ins %0d step %0d: got %h, required %h",
                             i, k, got_f, exp_f);
        end
        obs_k.push_back(int'(k_addr)); obs_r.push_back(int'(n_read_addr));
        obs_w.push_back(int'(n_write_addr)); obs_nb.push_back(int'(n_bank_sel));
        obs_kwe.push_back(k_write_en); obs_pool.push_back(do_pooling);
        obs_nwe.push_back(n_write_en);
        obs_any.push_back(k_write_en | n_load_en | n_read_en | n_write_en | do_pooling);
      end
      pend = take;
    end
    @(posedge CLK); #1;
    checks++;
    if ({k_write_en, n_load_en, n_read_en, n_write_en, do_pooling, busy} !== 6'b0 ||
        {k_addr, n_read_addr, n_write_addr} !==
        {m_ka[AB-1:0], m_ra[AB-1:0], m_wa[AB-1:0]}) begin
      errors++; $display("FAIL idle_hold: got strobes/busy %b addrs %h %h %h, required 0 and %h %h %h",
                         {k_write_en, n_load_en, n_read_en, n_write_en, do_pooling, busy},
                         k_addr, n_read_addr, n_write_addr, m_ka, m_ra, m_wa);
    end
    {m_kwe, m_ld, m_rd, m_nwe, m_pool} = '0;
  endtask

  task automatic clear_obs();
    obs_k.delete(); obs_r.delete(); obs_w.delete(); obs_nb.delete();
    obs_kwe.delete(); obs_pool.delete(); obs_nwe.delete(); obs_any.delete();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({n_read_addr, n_write_addr, k_addr, n_bank_sel, k_bank_sel, n_load_en, n_read_en,
         n_write_en, k_write_en, wdata, do_pooling, busy, err_illegal} !== '0 || ins_ready !== 1'b1)
    begin
      errors++; $display("FAIL %s: got addrs %h %h %h busy %b err %b ready %b, required all 0, ready 1",
                         name, n_read_addr, n_write_addr, k_addr, busy, err_illegal, ins_ready);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset_state");
    RSTN = 1'b1;
    model_reset();
  endtask

  task automatic test_load_k();
    logic [IW-1:0] p[$];
    clear_obs();
    p = '{mk(1, 0, 0, 0, 4), mk(2, 0, 0, 0, 0), mk(2, 2, 1, 6, 16'h1234)};
    run_program(p, 1);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (obs_k[j+1] != j || obs_kwe[j+1] !== 1'b1) begin
        errors++; $display("FAIL load_k_seq %0d: got addr %0d we %b, required addr %0d we 1",
                           j, obs_k[j+1], obs_kwe[j+1], j);
      end
    end
  endtask

  task automatic test_wrap();
    logic [IW-1:0] p[$];
    int bad, first;
    clear_obs();
    p = '{mk(1, 0, 1, 0, 0), mk(4, 0, 0, 0, 0)};
    for (int j = 0; j < 8; j++) p.push_back(mk(4, 2, 1, 255, j));
    run_program(p, 1);
    bad = 0; first = -1;
    for (int j = 0; j < 2048; j++) begin
      if (obs_r[j+2] != ((j + 1) % 2048)) begin bad++; if (first < 0) first = j; end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL read_wrap: got %0d bad addrs (first at step %0d = %0d), required 0",
                         bad, first, obs_r[first+2]);
    end
  endtask

  task automatic test_pool();
    logic [IW-1:0] p[$];
    int s;
    clear_obs();
    p = '{mk(1, 0, 1, 0, 8), mk(1, 0, 2, 0, 2), mk(1, 0, 3, 0, 4), mk(4, 0, 1, 0, 0),
          mk(5, 0, 0, 0, 0), mk(6, 3, 3, 1, 7)};
    run_program(p, 2);
    s = obs_r.size();
    checks++;
    if (obs_r[s-2] != 16 || obs_r[s-1] != 32 || obs_w[s-2] != 4 || obs_w[s-1] != 8) begin
      errors++; $display("FAIL pool_addr: got rd %0d,%0d wr %0d,%0d, required rd 16,32 wr 4,8",
                         obs_r[s-2], obs_r[s-1], obs_w[s-2], obs_w[s-1]);
    end
    checks++;
    if ({obs_pool[s-2], obs_pool[s-1], obs_nwe[s-2], obs_nwe[s-1]} !== 4'b1111) begin
      errors++; $display("FAIL pool_strobes: got %b, required 1111",
                         {obs_pool[s-2], obs_pool[s-1], obs_nwe[s-2], obs_nwe[s-1]});
    end
  endtask

  task automatic test_bank();
    logic [IW-1:0] p[$];
    int exp_nb[5] = '{1, 2, 3, 0, 1};
    clear_obs();
    p = '{mk(3, 1, 0, 0, 0)};
    for (int j = 0; j < 5; j++) p.push_back(mk(3, 1, 2, 0, j));
    run_program(p, 0);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (obs_nb[j+1] != exp_nb[j]) begin
        errors++; $display("FAIL bank_seq %0d: got %0d, required %0d", j, obs_nb[j+1], exp_nb[j]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [IW-1:0] p[$];
    clear_obs();
    p = '{mk(15, 2, 2, 9, 16'hbeef), mk(4, 1, 1, 1, 5), mk(2, 2, 2, 2, 6)};
    run_program(p, 2);
    checks++;
    if (obs_any[0] !== 1'b0) begin
      errors++; $display("FAIL illegal_strobes: got %b, required 0", obs_any[0]);
    end
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: got %b, required 1", err_illegal);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [IW-1:0] p[$];
      for (int j = 0; j < 15; j++) begin
        int op = $urandom_range(0, 7);
        if (op == 7) op = $urandom_range(7, 15);
        p.push_back(mk(op, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 6), $urandom_range(0, 65535)));
      end
      run_program(p, 2);
    end
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] p[$];
    p = '{mk(1, 0, 1, 0, 3)};
    run_program(p, 0);
    instruction = mk(5, 2, 0, 10, 77); ins_valid = 1'b1;
    @(posedge CLK); #1; ins_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b1 || n_write_en !== 1'b1) begin
      errors++; $display("FAIL mid_burst_active: got busy %b we %b, required 1 1", busy, n_write_en);
    end
    RSTN = 1'b0;
    @(posedge CLK); #1;
    check_all_zero("reset_mid_burst");
    RSTN = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, n_write_en, n_write_addr} !== '0) begin
      errors++; $display("FAIL no_replay: got busy %b we %b addr %0d, required 0 0 0",
                         busy, n_write_en, n_write_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load_k();
    test_wrap();
    test_pool();
    test_bank();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
